// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: PC register, imem req/ready fetch, field decode, next-PC select.
// Optional fetch-address range/alignment checking is compiled in with IFU_ADDR_CHECK_EN.
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        npc_sel,
  input  logic        j_ctl,
  input  logic        jr_ctl,
  input  logic        bltzal,
  input  logic        zero,
  input  logic        positive,
  input  logic [31:0] rs_data,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
`ifdef IFU_ADDR_CHECK_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc;
  logic [31:0] br_target;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Priority order matters: jr beats j when the decoder asserts both.
  always_comb begin
    npc = pc_plus4;
    if (jr_ctl)
      npc = rs_data;
    else if (j_ctl)
      npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (bltzal && !positive && !zero)
      npc = br_target;
    else if (npc_sel && !bltzal && zero)
      npc = br_target;
  end

`ifdef IFU_ADDR_CHECK_EN
  localparam logic [32:0] ADDR_END = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

  logic err_q, err_d;
  logic addr_ok;

  assign addr_ok   = (npc[1:0] == 2'b00) && (npc >= RESET_PC) && ({1'b0, npc} < ADDR_END);
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFU_ADDR_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d    = npc;
        state_d = S_FETCH;
`ifdef IFU_ADDR_CHECK_EN
        if (!addr_ok) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
`endif
      end
`ifdef IFU_ADDR_CHECK_EN
      S_ERR:   state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
`ifdef IFU_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IFU_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign imm16       = instr_q[15:0];

endmodule
